// File: rtl/mmu_layer_sequencer_if.sv
// Result stream bundle for mmu_layer_sequencer: valid/ready handshake carrying y[j] and its index.
interface mmu_layer_sequencer_if;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [7:0]  res_idx;

  modport master (output res_valid, output res_data, output res_idx, input res_ready);
  modport slave  (input res_valid, input res_data, input res_idx, output res_ready);
endinterface

// File: rtl/mmu_layer_sequencer.sv
// Dense-layer sequencer: reads bias/x/w through the shared MMU port, accumulates in fixed point,
// streams saturated y[j]. Optional output ReLU when MMU_SEQ_RELU_EN is defined.
module mmu_layer_sequencer #(
  parameter int unsigned N_IN        = 6,
  parameter int unsigned N_OUT       = 3,
  parameter logic [15:0] DATA_BASE   = 16'h0000,
  parameter logic [15:0] WEIGHT_BASE = 16'h0100,
  parameter logic [15:0] BIAS_BASE   = 16'h0200,
  parameter int unsigned FRAC        = 8,
  parameter int unsigned ACC_W       = 40
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  input  logic                         host_req,
  input  logic                         host_we,
  input  logic [15:0]                  host_addr,
  input  logic [15:0]                  host_wdata,
  output logic                         host_gnt,
  output logic [15:0]                  host_rdata,
  output logic [15:0]                  mmu_addr,
  output logic                         mmu_we,
  output logic [15:0]                  mmu_wdata,
  input  logic [15:0]                  mmu_rdata,
  mmu_layer_sequencer_if.master        res
);

  localparam logic [7:0] LAST_I = 8'(N_IN - 1);
  localparam logic [7:0] LAST_J = 8'(N_OUT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32'sd32768);

  typedef enum logic [2:0] {
    S_IDLE, S_BIAS, S_XREQ, S_WREQ, S_LAST, S_OUT, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              i_q, j_q;
  logic signed [15:0]      x_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [15:0]             addr_q;
  logic [15:0]             res_data_q;
  logic [7:0]              res_idx_q;
  logic                    res_valid_q, busy_q, done_q;

  logic signed [31:0]      prod;
  logic signed [ACC_W-1:0] prod_ext, bias_ext, acc_sh;
  logic [15:0]             sat_c, res_val_c;

  assign host_rdata    = mmu_rdata;
  assign busy          = busy_q;
  assign done          = done_q;
  assign res.res_valid = res_valid_q;
  assign res.res_data  = res_data_q;
  assign res.res_idx   = res_idx_q;

  // Next state and MMU port mux; the host owns the port only in IDLE.
  always_comb begin
    state_d   = state_q;
    host_gnt  = 1'b0;
    mmu_we    = 1'b0;
    mmu_wdata = 16'h0000;
    mmu_addr  = addr_q;
    case (state_q)
      S_IDLE: begin
        host_gnt  = host_req & ~start;
        mmu_we    = host_req & ~start & host_we;
        mmu_addr  = host_addr;
        mmu_wdata = host_wdata;
        if (start) state_d = S_BIAS;
      end
      S_BIAS: begin
        mmu_addr = BIAS_BASE + 16'(j_q);
        state_d  = S_XREQ;
      end
      S_XREQ: begin
        mmu_addr = DATA_BASE + 16'(i_q);
        state_d  = S_WREQ;
      end
      S_WREQ: begin
        mmu_addr = WEIGHT_BASE + 16'(32'(j_q) * N_IN) + 16'(i_q);
        state_d  = (i_q == LAST_I) ? S_LAST : S_XREQ;
      end
      S_LAST: state_d = S_OUT;
      S_OUT:  if (res.res_ready) state_d = (j_q == LAST_J) ? S_DONE : S_BIAS;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // MAC datapath: read data always answers the address issued one cycle earlier.
  always_comb begin
    prod     = 32'(x_q) * 32'($signed(mmu_rdata));
    prod_ext = ACC_W'(prod);
    bias_ext = ACC_W'($signed(mmu_rdata)) <<< FRAC;
    acc_d    = acc_q;
    case (state_q)
      S_XREQ:  acc_d = (i_q == 8'd0) ? bias_ext : acc_q + prod_ext;
      S_LAST:  acc_d = acc_q + prod_ext;
      default: acc_d = acc_q;
    endcase
    acc_sh = acc_d >>> FRAC;
    if (acc_sh > SAT_MAX)      sat_c = 16'h7FFF;
    else if (acc_sh < SAT_MIN) sat_c = 16'h8000;
    else                       sat_c = acc_sh[15:0];
`ifdef MMU_SEQ_RELU_EN
    res_val_c = sat_c[15] ? 16'h0000 : sat_c;
`else
    res_val_c = sat_c;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      x_q         <= 16'sd0;
      acc_q       <= '0;
      addr_q      <= 16'h0000;
      res_data_q  <= 16'h0000;
      res_idx_q   <= 8'd0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      acc_q   <= acc_d;
      // Address is held through LAST/OUT/DONE so nothing moves on the port while stalled.
      if (state_q == S_BIAS || state_q == S_XREQ || state_q == S_WREQ) addr_q <= mmu_addr;
      case (state_q)
        S_IDLE: if (start) begin
          i_q <= 8'd0;
          j_q <= 8'd0;
        end
        S_WREQ: begin
          x_q <= $signed(mmu_rdata);
          if (i_q != LAST_I) i_q <= i_q + 8'd1;
        end
        S_LAST: begin
          res_data_q  <= res_val_c;
          res_idx_q   <= j_q;
          res_valid_q <= 1'b1;
        end
        S_OUT: if (res.res_ready) begin
          res_valid_q <= 1'b0;
          if (j_q != LAST_J) begin
            j_q <= j_q + 8'd1;
            i_q <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
